// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative signed/unsigned multiply/divide unit for the EX stage
//
// Optional build macro: MULDIV_DIV0_FAST_EN. When it is defined, a divide by zero
// finishes after one CALC edge. When it is not defined, a divide by zero takes the
// full WIDTH edges.
//
// op_i encoding: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
// Result layout: mul -> {hi, lo} product; div -> {remainder, quotient}.

module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;     // latched op_i[1]
  logic               neg_a;      // dividend/multiplicand negative in signed mode
  logic               neg_b;      // divisor/multiplier negative in signed mode
  logic               b_zero;     // latched divisor was zero
  logic [WIDTH-1:0]   a_raw;      // raw dividend, needed for the divide-by-zero result
  logic [WIDTH-1:0]   b_mag;      // magnitude of operand 2
  logic [2*WIDTH-1:0] work;       // mul: {partial hi, shifting multiplier}; div: {rem, quotient}

  logic               accept;
  logic               last_iter;
  logic               finish;

  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] work_next;

  logic [2*WIDTH-1:0] mul_final;
  logic [WIDTH-1:0]   quot_final;
  logic [WIDTH-1:0]   rem_final;
  logic [2*WIDTH-1:0] final_res;

  assign accept    = (state == IDLE) && start_i && !annul_i;
  assign last_iter = (cnt == LAST_ITER);

`ifdef MULDIV_DIV0_FAST_EN
  assign finish = last_iter || (is_div && b_zero);
`else
  assign finish = last_iter;
`endif

  // Operand magnitudes taken at the accepting edge; unsigned modes pass through
  always_comb begin
    a_mag_in = opdata1_i;
    b_mag_in = opdata2_i;
    if (op_i[0] && opdata1_i[WIDTH-1]) a_mag_in = -opdata1_i;
    if (op_i[0] && opdata2_i[WIDTH-1]) b_mag_in = -opdata2_i;
  end

  // One shift-add multiply step and one restoring divide step on the work register
  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, b_mag} : '0);
    mul_next  = {mul_sum, work[WIDTH-1:1]};
    div_shift = {work, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, b_mag};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    end else begin
      div_next = div_shift[2*WIDTH-1:0];
    end
    work_next = is_div ? div_next : mul_next;
  end

  // Sign correction of the final step's magnitudes and divide-by-zero override
  always_comb begin
    mul_final  = (neg_a ^ neg_b) ? -mul_next : mul_next;
    quot_final = div_next[WIDTH-1:0];
    rem_final  = div_next[2*WIDTH-1:WIDTH];
    if (neg_a ^ neg_b) quot_final = -div_next[WIDTH-1:0];
    if (neg_a)         rem_final  = -div_next[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      final_res = mul_final;
    end else if (b_zero) begin
      final_res = {a_raw, {WIDTH{1'b1}}};
    end else begin
      final_res = {rem_final, quot_final};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; annul aborts everywhere except DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = CALC;
      end
      CALC: begin
        if (annul_i) begin
          state_next = IDLE;
        end else if (finish) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs: ready only in DONE; stall while a request is being accepted or iterating
  always_comb begin
    ready_o    = (state == DONE);
    stallreq_o = accept || (state == CALC);
  end

  // Operand latch, iteration counter and work register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      b_mag  <= '0;
      work   <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op_i[1];
      neg_a  <= op_i[0] && opdata1_i[WIDTH-1];
      neg_b  <= op_i[0] && opdata2_i[WIDTH-1];
      b_zero <= (opdata2_i == '0);
      a_raw  <= opdata1_i;
      b_mag  <= b_mag_in;
      work   <= {{WIDTH{1'b0}}, a_mag_in};
    end else if ((state == CALC) && !annul_i) begin
      cnt    <= cnt + 1'b1;
      work   <= work_next;
    end
  end

  // Result register: loaded only on the edge that enters DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_o <= '0;
    end else if ((state == CALC) && (state_next == DONE)) begin
      result_o <= final_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit (WIDTH=32)

module tb_ex_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 32;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op_sel;
  logic          annul;
  logic [W-1:0]  d1;
  logic [W-1:0]  d2;
  logic [2*W-1:0] result;
  logic          ready;
  logic          stallreq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_res = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
    string       name;
  } vec_t;

  vec_t tbl[12];

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .op_i       (op_sel),
    .annul_i    (annul),
    .opdata1_i  (d1),
    .opdata2_i  (d2),
    .result_o   (result),
    .ready_o    (ready),
    .stallreq_o (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    logic [63:0] p;
    la = $signed(a);
    lb = $signed(b);
    case (op)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = la * lb;
      2'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = la / lb;
          r = la % lb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && b == 0) ? DIV0_LAT : W;
  endfunction

  // Issue one operation from just after a rising edge and watch it to completion
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit hold, input string nm);
    int first;
    int nready;
    int stall_bad;
    logic [63:0] got;
    first = 0;
    nready = 0;
    stall_bad = 0;
    got = '0;
    start = 1'b1;
    annul = 1'b0;
    op_sel = op;
    d1 = a;
    d2 = b;
    #1;
    chk({nm, "_stall_req"}, 64'(stallreq), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    op_sel = 2'($urandom);
    d1 = $urandom;
    d2 = $urandom;
    for (int n = 1; n <= lat + 2; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        nready++;
        if (first == 0) begin
          first = n;
          got = result;
          if (stallreq !== 1'b0) stall_bad++;
        end
        start = 1'b0;
      end else if (n < lat && stallreq !== 1'b1) begin
        stall_bad++;
      end else if (n > lat && stallreq !== 1'b0) begin
        stall_bad++;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, 64'(first), 64'(lat));
    chk({nm, "_ready_pulses"}, 64'(nready), 64'd1);
    chk({nm, "_result"}, got, exp);
    chk({nm, "_result_hold"}, result, exp);
    chk({nm, "_stall_profile"}, 64'(stall_bad), 64'd0);
    last_res = exp;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    int          nready;

    tbl[0]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 32, "umul_max_x2"};
    tbl[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 32, "smul_m3_x7"};
    tbl[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 32, "sdiv_m7_2"};
    tbl[3]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32, "sdiv_min_m1"};
    tbl[4]  = '{2'd2, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, DIV0_LAT, "udiv_5_0"};
    tbl[5]  = '{2'd2, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 32, "udiv_100_7"};
    tbl[6]  = '{2'd3, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 32, "sdiv_7_m2"};
    tbl[7]  = '{2'd3, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, DIV0_LAT, "sdiv_m5_0"};
    tbl[8]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32, "smul_min_min"};
    tbl[9]  = '{2'd0, 32'h0000_0000, 32'h0001_2345, 64'h0000_0000_0000_0000, 32, "umul_zero"};
    tbl[10] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 32, "smul_m1_m1"};
    tbl[11] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, "umul_max_max"};

    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    op_sel = 2'd0;
    d1 = '0;
    d2 = '0;
    #2;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stall", 64'(stallreq), 64'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, 1'b0, tbl[i].name);
    end

    for (int k = 0; k < 60; k++) begin
      rop = 2'($urandom);
      sel = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (sel == 2) begin
        ra = $urandom_range(0, 300) - 150;
        rb = $urandom_range(0, 40) - 20;
      end
      do_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop, rb), 1'b0, "rand");
    end

    // Annul arriving at the 10th CALC edge of a divide
    nready = 0;
    start = 1'b1;
    op_sel = 2'd3;
    d1 = 32'd1000;
    d2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (ready) nready++;
      if (k == 9) annul = 1'b1;
    end
    @(posedge clk);
    #1;
    annul = 1'b0;
    if (ready) nready++;
    chk("annul_no_ready", 64'(nready), 64'd0);
    chk("annul_stall_drop", 64'(stallreq), 64'd0);
    chk("annul_result_kept", result, last_res);
    do_op(2'd2, 32'd1000, 32'd7, model(2'd2, 32'd1000, 32'd7), 32, 1'b0, "after_annul");

    // start held high through CALC must not restart the operation
    do_op(2'd1, 32'h1234_5678, 32'hFFFF_0001, model(2'd1, 32'h1234_5678, 32'hFFFF_0001), 32, 1'b1, "hold_start");

    // start with annul in IDLE is refused
    start = 1'b1;
    annul = 1'b1;
    op_sel = 2'd0;
    d1 = 32'd3;
    d2 = 32'd3;
    #1;
    chk("idle_annul_stall", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    chk("idle_annul_not_taken", 64'(stallreq), 64'd0);
    do_op(2'd0, 32'd9, 32'd11, 64'd99, 32, 1'b0, "after_idle_annul");

    // Asynchronous reset in the middle of CALC
    start = 1'b1;
    op_sel = 2'd0;
    d1 = 32'hDEAD_BEEF;
    d2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_result", result, 64'd0);
    chk("async_rst_ready", 64'(ready), 64'd0);
    chk("async_rst_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(ready), 64'd0);
    chk("post_rst_result", result, 64'd0);
    do_op(2'd3, 32'hFFFF_FF00, 32'd16, model(2'd3, 32'hFFFF_FF00, 32'd16), 32, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It completes the EX-stage MUL/DIV path that is currently unimplemented.
- Generalised over operand width, with four modes: signed/unsigned multiply and signed/unsigned divide.
- Holds EX via a stall request while it iterates, then returns a 2*WIDTH-bit {HI,LO} result with a one-cycle ready pulse.
- Supports annul, so a flushed instruction can abort an operation in flight.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH. Legal values are 8 to 64.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation select: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- annul_i  in  1  abort the current or requested operation.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- result_o  out  2*WIDTH  mul: full product {hi,lo}; div: {remainder, quotient}.
- ready_o  out  1  result valid; one-cycle pulse.
- stallreq_o  out  1  EX stall request to the stall controller.

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, result_o=0, ready_o=0, stallreq_o=0. Applies at any time, including mid-operation; no partial result survives.
- States and transitions:
  - IDLE: if start_i=1 and annul_i=0 at an edge, latch op_i and both operands, then go to CALC with counter=0.
  - CALC: one iteration per edge. After the WIDTH-th iteration, go to DONE.
  - DONE: ready_o=1 and result_o valid for exactly this one cycle; next edge goes to IDLE.
  - Any state except DONE: annul_i=1 at an edge returns to IDLE, with no ready pulse and result_o unchanged. In DONE, annul_i has no effect.
- Latency: ready_o rises exactly WIDTH edges after the accepting edge (32 for WIDTH=32).
- stallreq_o is combinational, defined as (IDLE & start_i & ~annul_i) | CALC. It is low in DONE so the pipeline advances on that cycle.
- Operands are latched at the accepting edge; input changes during CALC are ignored. start_i outside IDLE is ignored.
- Multiply:
  - Shift-add on magnitudes, one bit per iteration.
  - Signed mode takes operand magnitudes and negates the 2*WIDTH product when the signs differ.
- Divide:
  - Restoring division on magnitudes, one quotient bit per iteration.
  - Signed mode: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^WIDTH per half. Signed MIN / -1 gives quotient = MIN and remainder = 0.
- Divide by zero (either signedness): result_o = {opdata1, all-ones}. Latency is still WIDTH edges unless the optional feature is enabled.
- result_o holds its last value until the next DONE or reset.

Optional Feature:
- Macro: MULDIV_DIV0_FAST_EN.
- Defined: a divide whose latched divisor is 0 goes from CALC to DONE after a single iteration edge. ready_o then pulses 1 edge after acceptance, with the same divide-by-zero result. Multiplies and non-zero divides are unaffected.
- Undefined: divide-by-zero takes the full WIDTH edges.

Test Plan:
- Unsigned mul, WIDTH=32: 0xFFFFFFFF * 0x00000002 -> result_o = 0x00000001_FFFFFFFE. ready_o pulses exactly 32 edges after acceptance, and stallreq_o stays high for the 32 cycles before ready.
- Signed mul -3 * 7 -> result 0xFFFFFFFF_FFFFFFEB.
- Signed div -7 / 2 -> {rem 0xFFFFFFFF, quot 0xFFFFFFFD}.
- Signed div 0x80000000 / 0xFFFFFFFF -> {rem 0, quot 0x80000000}.
- Unsigned div 5 / 0:
  - Without the macro: {0x00000005, 0xFFFFFFFF} after 32 edges.
  - With MULDIV_DIV0_FAST_EN: same result after 1 edge.
- Start a divide, then assert annul_i at the 10th CALC edge:
  - No ready pulse; stallreq_o drops the following cycle.
  - A new start next cycle is accepted and completes correctly.
- Assert rst mid-CALC: all outputs go to 0 immediately, without waiting for a clock edge. Operation resumes normally after rst is released.
- Hold start_i high during CALC: no re-acceptance. In the same IDLE cycle, start_i=1 with annul_i=1 -> not accepted and stallreq_o=0.
